// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin scheduler sharing one sequential signed Booth multiplier among NREQ requesters
module booth_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int MP_W = 8,
  parameter int MC_W = 8,
  parameter int PD_W = 15,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*MP_W-1:0] mtp_in,
  input  logic [NREQ*MC_W-1:0] mtc_in,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      res_valid,
  output logic [PD_W-1:0]      res_data,
  output logic                 res_err,
  output logic                 busy,
  output logic                 m_St,
  output logic [MP_W-1:0]      m_Mtp,
  output logic [MC_W-1:0]      m_Mtc,
  input  logic                 m_Ready,
  input  logic [PD_W-1:0]      m_Product
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, g;
  logic [CW-1:0] cnt;
  logic ready_q, hit, done_ev, tmo;
  assign hit = |req;
  assign done_ev = m_Ready & ~ready_q;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    g = ptr;
    for (int k = NREQ; k >= 1; k--)
      if (req[PW'((int'(ptr) + k) % NREQ)]) g = PW'((int'(ptr) + k) % NREQ);
  end
  always_comb begin
    state_n = state == IDLE  ? (hit ? START : IDLE) :
              state == START ? WAIT :
              state == WAIT  ? ((done_ev || tmo) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= PW'(NREQ - 1);
      cnt <= '0;
      ready_q <= 1'b0;
      ack <= '0;
      res_valid <= '0;
      res_data <= '0;
      res_err <= 1'b0;
      busy <= 1'b0;
      m_St <= 1'b0;
      m_Mtp <= '0;
      m_Mtc <= '0;
    end else begin
      ready_q <= m_Ready;
      busy <= state_n != IDLE;
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      ack <= '0;
      m_St <= 1'b0;
      res_valid <= state == DONE ? NREQ'(1) << ptr : '0;
      if (|res_valid) res_err <= 1'b0;
      if (state == IDLE && hit) begin
        ptr <= g;
        ack <= NREQ'(1) << g;
        m_St <= 1'b1;
        m_Mtp <= mtp_in[g*MP_W +: MP_W];
        m_Mtc <= mtc_in[g*MC_W +: MC_W];
      end
      if (state == WAIT && (done_ev || tmo)) begin
        res_data <= done_ev ? m_Product : '0;
        res_err <= ~done_ev;
      end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: scoreboard bench for booth_mult_arbiter with a behavioural Booth multiplier
module tb_booth_mult_arbiter;
  localparam int NREQ = 4, MP_W = 8, MC_W = 8, PD_W = 15, TIMEOUT = 64;
  typedef struct {int idx; logic [PD_W-1:0] data; logic err;} res_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, hold = '0;
  logic [NREQ*MP_W-1:0] mtp_in = '0;
  logic [NREQ*MC_W-1:0] mtc_in = '0;
  logic [NREQ-1:0] ack, res_valid;
  logic [PD_W-1:0] res_data;
  logic res_err, busy, m_St, m_Ready;
  logic [MP_W-1:0] m_Mtp;
  logic [MC_W-1:0] m_Mtc;
  logic stuck = 1'b0, mr = 1'b1;
  logic [PD_W-1:0] mp = '0, mprod = '0;
  int mcnt = 0, cyc = 0, n_chk = 0, n_fail = 0;
  int ack_q[$];
  res_t res_q[$];
  booth_mult_arbiter #(.NREQ(NREQ), .MP_W(MP_W), .MC_W(MC_W), .PD_W(PD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .mtp_in(mtp_in), .mtc_in(mtc_in), .ack(ack),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err), .busy(busy),
    .m_St(m_St), .m_Mtp(m_Mtp), .m_Mtc(m_Mtc), .m_Ready(m_Ready), .m_Product(mp)
  );
  assign m_Ready = stuck | mr;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    if (m_St) begin
      mr <= 1'b0;
      mcnt <= 5;
      mprod <= PD_W'(int'($signed(m_Mtp)) * int'($signed(m_Mtc)));
    end else if (mcnt == 1) begin
      mcnt <= 0;
      mr <= 1'b1;
      mp <= mprod;
    end else if (mcnt > 1) mcnt <= mcnt - 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [PD_W-1:0] p(input int v);
    return PD_W'(v);
  endfunction
  task automatic set_ops(input int i, input int a, input int b);
    mtp_in[i*MP_W +: MP_W] = MP_W'(a);
    mtc_in[i*MC_W +: MC_W] = MC_W'(b);
  endtask
  task automatic expect_op(input int i, input int prod, input logic err);
    ack_q.push_back(i);
    res_q.push_back('{i, p(prod), err});
  endtask
  task automatic wait_ack(output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 200);
    if (ack == '0) chk("ack_wait", 0, 1);
    else t = cyc;
  endtask
  task automatic drain();
    int n = 0;
    while (res_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", res_q.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_St"}, m_St, 0);
    chk({tag, "_m_Mtp"}, m_Mtp, 0);
    chk({tag, "_m_Mtc"}, m_Mtc, 0);
  endtask
  initial begin
    int t0, t1, n;
    int ea;
    res_t er;
    logic st_prev;
    st_prev = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (m_St) chk("st_width", st_prev, 0);
        st_prev = m_St;
        if (ack != '0) begin
          if (ack_q.size() == 0) chk("ack_unexpected", ack, 0);
          else begin
            ea = ack_q.pop_front();
            chk("ack_grant", ack, NREQ'(1) << ea);
            chk("st_with_ack", m_St, 1);
          end
        end
        if (res_valid != '0) begin
          if (res_q.size() == 0) chk("res_unexpected", res_valid, 0);
          else begin
            er = res_q.pop_front();
            chk("res_valid_idx", res_valid, 1 << er.idx);
            chk("res_data", res_data, er.data);
            chk("res_err", res_err, er.err);
          end
        end
      end
      forever begin
        @(negedge clk);
        req = req & ~(ack & ~hold);
      end
    join_none
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk) #1;
    set_ops(0, 51, 102);
    expect_op(0, 5202, 1'b0);
    req[0] = 1'b1;
    t0 = cyc;
    wait_ack(t1);
    chk("ack_latency", t1 - t0, 1);
    drain();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    set_ops(0, -90, 102);
    set_ops(1, 107, -114);
    set_ops(2, -52, -103);
    set_ops(3, -9, -13);
    expect_op(0, -9180, 1'b0);
    expect_op(1, -12198, 1'b0);
    expect_op(2, 5356, 1'b0);
    expect_op(3, 117, 1'b0);
    req = 4'b1111;
    drain();
    set_ops(1, 3, 5);
    set_ops(3, -7, 4);
    set_ops(0, 10, -10);
    expect_op(1, 15, 1'b0);
    expect_op(3, -28, 1'b0);
    expect_op(1, 15, 1'b0);
    expect_op(3, -28, 1'b0);
    expect_op(0, -100, 1'b0);
    expect_op(1, 15, 1'b0);
    expect_op(3, -28, 1'b0);
    hold = 4'b1010;
    @(posedge clk) #1;
    req = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      wait_ack(t0);
      if (i == 3) req[0] = 1'b1;
      if (i == 6) begin
        hold = '0;
        req = '0;
      end
    end
    drain();
    stuck = 1'b1;
    set_ops(2, 6, 7);
    expect_op(2, 0, 1'b1);
    @(posedge clk) #1;
    req[2] = 1'b1;
    wait_ack(t0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid == '0 && n < 200);
    t1 = cyc;
    chk("timeout_latency", t1 - t0, TIMEOUT + 2);
    drain();
    stuck = 1'b0;
    expect_op(2, 42, 1'b0);
    @(posedge clk) #1;
    req[2] = 1'b1;
    drain();
    set_ops(1, 2, 3);
    ack_q.push_back(1);
    @(posedge clk) #1;
    req[1] = 1'b1;
    wait_ack(t0);
    repeat (3) @(negedge clk);
    chk("busy_in_wait", busy, 1);
    #1 rst = 1'b1;
    #1 chk_zero("midop_reset");
    set_ops(0, 10, -10);
    expect_op(0, -100, 1'b0);
    expect_op(2, 42, 1'b0);
    req = 4'b0101;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain();
    set_ops(3, -20, 33);
    expect_op(3, -660, 1'b0);
    @(posedge clk) #1;
    req[3] = 1'b1;
    wait_ack(t0);
    set_ops(3, 99, -5);
    n = 0;
    while (busy && n < 100) begin
      chk("stable_mtp", m_Mtp, 8'hEC);
      chk("stable_mtc", m_Mtc, 8'h21);
      @(negedge clk);
      n++;
    end
    drain();
    repeat (10) @(negedge clk);
    chk("ack_q_empty", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
